// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings, FSM states and iteration count for the
//               sequential multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int unsigned MDU_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_32bit
// Description : 32-bit adder with a fixed carry-in; CARRY_IN_0=1 turns
//               a + ~b into a - b.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_32bit #(
    parameter bit CARRY_IN_0 = 1'b0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + 33'(CARRY_IN_0);

endmodule : adder_32bit
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Sequential MIPS MULT/MULTU/DIV/DIVU unit with HI/LO, one bit
//               per cycle. Divide support is compiled in with MDU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] mt_wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        illegal_op,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [4:0] LAST_ITER = 5'(MDU_ITER - 1);

    mdu_state_e  r_state, w_state_nxt;
    logic [1:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [4:0]  r_cnt;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_done;
    logic        r_dbz;
    logic        r_illegal;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_idle;
    logic        w_launch;
    logic        w_reject;
    logic        w_is_div;
    logic        w_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_mag_rs;
    logic [31:0] w_mag_rt;
    logic [31:0] w_rem_sh;
    logic        w_take;
    logic        w_div_zero;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic [31:0] w_add0_a, w_add0_b, w_sum0;
    logic [31:0] w_add1_a, w_add1_b, w_sum1;
    logic        w_cout0, w_cout1;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_launch   = start && w_idle && (DIV_EN || !op[1]);
    assign w_reject   = start && w_idle && !DIV_EN && op[1];
    assign w_is_div   = (r_op == MDU_DIV) || (r_op == MDU_DIVU);
    assign w_signed   = (r_op == MDU_MULT) || (r_op == MDU_DIV);
    assign w_rs_neg   = w_signed && r_rs[31];
    assign w_rt_neg   = w_signed && r_opb[31];
    assign w_mag_rs   = w_rs_neg ? w_sum1 : r_rs;
    assign w_mag_rt   = w_rt_neg ? w_sum0 : r_opb;
    assign w_rem_sh   = {r_acc_hi[30:0], r_acc_lo[31]};
    assign w_take     = r_acc_hi[31] || w_cout1;
    assign w_div_zero = (r_opb == 32'd0);

    // Both adders are time-shared: negation in PREP/FIX, accumulate/trial in ITER.
    always_comb begin
        w_add0_a = r_acc_hi;
        w_add0_b = r_opa;
        w_add1_a = w_rem_sh;
        w_add1_b = ~r_opb;
        case (r_state)
            ST_PREP: begin
                w_add0_a = ~r_opb;
                w_add0_b = 32'd1;
                w_add1_a = 32'd0;
                w_add1_b = ~r_rs;
            end
            ST_FIX: begin
                w_add0_a = ~r_acc_hi;
                w_add0_b = 32'd1;
                w_add1_a = 32'd0;
                w_add1_b = ~r_acc_lo;
            end
            default: ;
        endcase
    end

    adder_32bit #(.CARRY_IN_0(1'b0)) u_add_acc (
        .a         (w_add0_a),
        .b         (w_add0_b),
        .sum       (w_sum0),
        .carry_out (w_cout0)
    );

    adder_32bit #(.CARRY_IN_0(1'b1)) u_add_sub (
        .a         (w_add1_a),
        .b         (w_add1_b),
        .sum       (w_sum1),
        .carry_out (w_cout1)
    );

    always_comb begin
        w_fix_hi = r_acc_hi;
        w_fix_lo = r_acc_lo;
        if (w_is_div) begin
            if (w_div_zero) begin
                w_fix_hi = r_rs;
                w_fix_lo = 32'hFFFF_FFFF;
            end else begin
                if (r_neg_res) w_fix_lo = w_sum1;
                if (r_neg_rem) w_fix_hi = w_sum0;
            end
        end else if (r_neg_res) begin
            // Two's-complement of the 64-bit product: borrow into HI only when LO is zero.
            w_fix_lo = w_sum1;
            w_fix_hi = (r_acc_lo == 32'd0) ? w_sum0 : ~r_acc_hi;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = ST_ITER;
            ST_ITER: if (r_cnt == LAST_ITER) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 2'b00;
            r_rs      <= 32'd0;
            r_opa     <= 32'd0;
            r_opb     <= 32'd0;
            r_acc_hi  <= 32'd0;
            r_acc_lo  <= 32'd0;
            r_cnt     <= 5'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_op  <= op;
                        r_rs  <= rs_val;
                        r_opb <= rt_val;
                    end
                end
                ST_PREP: begin
                    r_opa     <= w_mag_rs;
                    r_opb     <= w_mag_rt;
                    r_neg_res <= w_rs_neg ^ w_rt_neg;
                    r_neg_rem <= w_rs_neg;
                    r_acc_hi  <= 32'd0;
                    r_acc_lo  <= w_is_div ? w_mag_rs : w_mag_rt;
                    r_cnt     <= 5'd0;
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_is_div && DIV_EN) begin
                        r_acc_hi <= w_take ? w_sum1 : w_rem_sh;
                        r_acc_lo <= {r_acc_lo[30:0], w_take};
                    end else if (r_acc_lo[0]) begin
                        {r_acc_hi, r_acc_lo} <= {w_cout0, w_sum0, r_acc_lo[31:1]};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= (r_state == ST_FIX) || w_reject;
            r_dbz     <= (r_state == ST_FIX) && w_is_div && w_div_zero;
            r_illegal <= w_reject;
        end
    end

    // The FIX write takes priority over a coincident MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= HILO_RST;
            r_lo <= HILO_RST;
        end else if (r_state == ST_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else begin
            if (hi_we) r_hi <= mt_wdata;
            if (lo_we) r_lo <= mt_wdata;
        end
    end

    assign busy        = !w_idle;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_illegal;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule : mult_div_unit
`default_nettype wire
